// File: rtl/regfile_pkg.sv
// Default sizing and shared types for the parametrised register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH    = 32;
  localparam int REGFILE_DEPTH    = 32;
  localparam int REGFILE_NUM_READ = 2;

  typedef logic [$clog2(REGFILE_DEPTH)-1:0] regaddr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker; exposes next-state pending so the top can
// register busy flags that line up with the write-first read bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wq_i,
  input  logic [AW-1:0]    write_reg_i,
  input  logic             reserve_i,
  input  logic [AW-1:0]    reserve_reg_i,
  input  logic             flush_i,
  output logic [DEPTH-1:0] pn_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             rq;

  assign rq = reserve_i && !flush_i && ({1'b0, reserve_reg_i} < DEPTH_W) &&
              !((ZERO_REG != 0) && (reserve_reg_i == '0));

  // Order matters: retire, then reserve (wins over same-register retire), then flush wins over all.
  always_comb begin
    pending_d = pending_q;
    if (wq_i) pending_d[write_reg_i] = 1'b0;
    if (rq) pending_d[reserve_reg_i] = 1'b1;
    if (flush_i) pending_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pn_o = pending_d;

endmodule

// File: rtl/regfile_param.sv
// Multi-read-port flop register file, registered reads with write-first bypass,
// plus a registered busy flag per read port from the pending-write scoreboard.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NUM_READ = REGFILE_NUM_READ,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write,
  input  logic [$clog2(DEPTH)-1:0]  writeReg,
  input  logic [WIDTH-1:0]          writeData,
  input  logic                      reserve,
  input  logic [$clog2(DEPTH)-1:0]  reserveReg,
  input  logic                      flush,
  input  logic [NUM_READ*$clog2(DEPTH)-1:0] readReg,
  output logic [NUM_READ*WIDTH-1:0] readData,
  output logic [NUM_READ-1:0]       readBusy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [NUM_READ*WIDTH-1:0] rdata_d, rdata_q;
  logic [NUM_READ-1:0]       busy_d, busy_q;
  logic [DEPTH-1:0]          pn;
  logic                      wq;

  assign wq = write && ({1'b0, writeReg} < DEPTH_W) &&
              !((ZERO_REG != 0) && (writeReg == '0));

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .wq_i          (wq),
    .write_reg_i   (writeReg),
    .reserve_i     (reserve),
    .reserve_reg_i (reserveReg),
    .flush_i       (flush),
    .pn_o          (pn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wq) begin
      mem_q[writeReg] <= writeData;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          in_rng;

    assign ra     = readReg[p*AW +: AW];
    assign in_rng = ({1'b0, ra} < DEPTH_W) && !((ZERO_REG != 0) && (ra == '0));

    assign rdata_d[p*WIDTH +: WIDTH] = !in_rng               ? '0        :
                                       (wq && ra == writeReg) ? writeData :
                                                                mem_q[ra];
    assign busy_d[p] = in_rng && pn[ra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      busy_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign readData = rdata_q;
  assign readBusy = busy_q;

endmodule
